// File: rtl/outport_uart_tx_pkg.sv
// Shared definitions for the OutPort UART transmitter: FSM encoding and frame geometry.
package outport_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = UART_DATA_BITS * BYTES_PER_WORD;
    localparam int TIMER_W        = 16;

endpackage

// File: rtl/outport_fifo.sv
// Synchronous circular FIFO; a push while full is taken only when a pop lands on the same edge.
module outport_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             push_ok, pop_ok;

    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // Storage needs no reset: contents are only observed behind a valid count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/outport_uart_tx.sv
// OutPort serial consumer: queues written words and sends each as four 8N1 frames, LSB byte first.
module outport_uart_tx
    import outport_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            clr,
    input  logic                            wr_en,
    input  logic [WORD_W-1:0]               wr_data,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt,
    output logic                            full,
    output logic                            overflow
);
    localparam logic [TIMER_W-1:0] BIT_LOAD  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic [1:0]         LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    uart_state_e         state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [2:0]          bit_q, bit_d;
    logic [1:0]          byte_q, byte_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic                tx_d, busy_d;
    logic                pop;
    logic                fifo_empty;
    logic [WORD_W-1:0]   fifo_dout;

    outport_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .full  (full),
        .empty (fifo_empty)
    );

    // The word shifts right one place per data bit, so bit 0 is always the
    // next bit on the wire and the following byte lines up after eight shifts.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        tx_d    = tx;
        busy_d  = busy;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    byte_d  = '0;
                    timer_d = BIT_LOAD;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LOAD;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LOAD;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shreg_q[1];
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LOAD;
                    if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        byte_d  = '0;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

    // A write is lost only when the queue is full and no pop frees a slot that edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                          overflow <= 1'b0;
        else if (wr_en && full && !pop)   overflow <= 1'b1;
    end

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx: a serial decoder checks every frame against a byte scoreboard.
module tb_outport_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        tx, busy, full, overflow;
    logic [2:0]  fifo_cnt;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b1;
    logic [7:0] exp_q [$];

    outport_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx       (tx),
        .busy     (busy),
        .fifo_cnt (fifo_cnt),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((busy || fifo_cnt != 0 || exp_q.size() != 0) && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n < 5000), 32'd1);
    endtask

    // Serial decoder: finds the first low sample, then samples each bit one cycle into its slot.
    initial begin
        logic [7:0] rx;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (clr || tx) continue;
            repeat (CPB + 1) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                rx[k] = tx;
                repeat (CPB) @(negedge clk);
            end
            stop_bit = tx;
            if (mon_en) begin
                check("stop_bit", 32'(stop_bit), 32'd1);
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_byte: got %0h, expected no frame", rx);
                end
                if (exp_q.size() != 0) check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
            end
            repeat (2) @(negedge clk);
        end
    end

    // Line must rest high whenever no word is in flight.
    always @(negedge clk) begin
        if (!clr && !busy) check("idle_tx_high", 32'(tx), 32'd1);
    end

    initial begin
        int n;
        bit saw_low;

        // 1: reset state, first-word latency, busy length
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        expect_word(32'h0000_00A5);
        wr_en = 1'b1; wr_data = 32'h0000_00A5;
        @(negedge clk);
        wr_en = 1'b0;
        check("lat_cnt_after_wr", 32'(fifo_cnt), 32'd1);
        check("lat_busy_after_wr", 32'(busy), 32'd0);
        @(negedge clk);
        check("lat_busy_after_pop", 32'(busy), 32'd1);
        check("lat_tx_start", 32'(tx), 32'd0);
        check("lat_cnt_after_pop", 32'(fifo_cnt), 32'd0);
        busy_len(n);
        check("t1_busy_len", 32'(n), 32'd160);
        wait_drain("t1_drain");

        // 2: byte order within a word
        expect_word(32'h4433_2211);
        wr_en = 1'b1; wr_data = 32'h4433_2211;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        busy_len(n);
        check("t2_busy_len", 32'(n), 32'd160);
        wait_drain("t2_drain");

        // 3: six back-to-back writes, sixth dropped
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 32'hC0DE_0000 + 32'(i);
            if (i < 5) expect_word(32'hC0DE_0000 + 32'(i));
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("t3_full", 32'(full), 32'd1);
        check("t3_cnt", 32'(fifo_cnt), 32'd4);
        check("t3_ovf", 32'(overflow), 32'd1);
        busy_len(n);
        check("t3_busy_len", 32'(n), 32'd796);  // 800 from the first pop, 4 already elapsed
        wait_drain("t3_drain");
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: write landing on the pop edge while full
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t4_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 32'h5A00_0010 + 32'(i);
            expect_word(32'h5A00_0010 + 32'(i));
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (156) @(negedge clk);
        check("t4_cnt_before", 32'(fifo_cnt), 32'd4);
        wr_en = 1'b1; wr_data = 32'h5A00_0099;
        expect_word(32'h5A00_0099);
        @(negedge clk);
        wr_en = 1'b0;
        check("t4_cnt_after", 32'(fifo_cnt), 32'd4);
        check("t4_ovf", 32'(overflow), 32'd0);
        wait_drain("t4_drain");

        // 5: clear in the middle of a data bit
        mon_en = 1'b0;
        wr_en = 1'b1; wr_data = 32'h0000_00F0;
        @(negedge clk);
        wr_data = 32'h1111_1111;
        @(negedge clk);
        wr_data = 32'h2222_2222;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (16) @(negedge clk);
        check("t5_tx_in_bit3", 32'(tx), 32'd0);
        check("t5_cnt_before", 32'(fifo_cnt), 32'd2);
        clr = 1'b1;
        wr_en = 1'b1; wr_data = 32'hDEAD_BEEF;
        #1;
        check("t5_clr_tx", 32'(tx), 32'd1);
        check("t5_clr_busy", 32'(busy), 32'd0);
        check("t5_clr_cnt", 32'(fifo_cnt), 32'd0);
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        clr = 1'b0;
        check("t5_wr_ignored", 32'(fifo_cnt), 32'd0);
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (!tx || busy) saw_low = 1'b1;
        end
        check("t5_stays_idle", 32'(saw_low), 32'd0);
        exp_q.delete();
        mon_en = 1'b1;

        // 6: random writes with random gaps
        for (int i = 0; i < 12; i++) begin
            logic [31:0] w;
            repeat ($urandom_range(0, 200)) @(negedge clk);
            if (!full) begin
                w = $urandom;
                expect_word(w);
                wr_en = 1'b1; wr_data = w;
                @(negedge clk);
                wr_en = 1'b0;
            end
        end
        wait_drain("t6_drain");
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_final_tx", 32'(tx), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
